// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the iterative multiply/divide unit.
//   md_op_e    : operation encoding presented on the op port
//   md_state_e : sequencing FSM states
//   md_cnt_w() : iteration counter width for a given operand width
package muldiv_pkg;

   localparam int MD_WIDTH = 32;

   function automatic int md_cnt_w(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

   localparam int MD_CNT_W = md_cnt_w(MD_WIDTH);

   typedef enum logic [1:0] {
      MD_MUL   = 2'b00,
      MD_UMULL = 2'b01,
      MD_SMULL = 2'b10,
      MD_UDIV  = 2'b11
   } md_op_e;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PREP = 3'd1,
      S_RUN  = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } md_state_e;

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one iteration of the multiply/divide datapath (purely combinational).
//   op_is_div_i : 1 = restoring-divide step, 0 = shift-add multiply step
//   acc_i       : 2*WIDTH working accumulator
//                   multiply: {partial product high, remaining multiplier bits}
//                   divide  : {partial remainder, remaining dividend / quotient bits}
//   operand_i   : multiplicand (multiply) or divisor (divide)
//   acc_o       : accumulator after this iteration
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic                 op_is_div_i,
   input  logic [2*WIDTH-1:0]   acc_i,
   input  logic [WIDTH-1:0]     operand_i,
   output logic [2*WIDTH-1:0]   acc_o
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] rem_sh;
   logic [WIDTH:0] diff;

   // NOTE: combinational logic uses blocking assignments and gives every
   // output a value on every path, so no latch is inferred.
   always_comb begin
      // Multiply: add the multiplicand into the high half when the current
      // multiplier LSB is set; the carry lands in the top bit after the shift.
      sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, operand_i} : '0);

      // Divide: shift the next dividend bit into the remainder. The shifted
      // remainder needs WIDTH+1 bits; bit WIDTH of the difference is the borrow.
      rem_sh = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
      diff   = rem_sh - {1'b0, operand_i};

      if (op_is_div_i) begin
         if (diff[WIDTH]) begin
            acc_o = {rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
         end else begin
            acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
         end
      end else begin
         acc_o = {sum, acc_i[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative MUL / UMULL / SMULL / UDIV unit, one bit per cycle.
//   clk, reset        : rising-edge clock, asynchronous active-high reset
//   start, op, a, b   : request, sampled only while idle
//   busy              : high while PREP, RUN or FIX
//   done              : one-cycle pulse, results valid
//   result_lo/hi      : product low/high (hi = 0 for MUL) or quotient/remainder
//   div_zero          : last UDIV had a zero divisor; held with the results
module muldiv_seq
   import muldiv_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_hi,
   output logic             div_zero
);

   localparam int CNT_W = md_cnt_w(WIDTH);

   md_state_e            state_q,      state_d;
   md_op_e               op_q,         op_d;
   logic [WIDTH-1:0]     a_q,          a_d;
   logic [WIDTH-1:0]     b_q,          b_d;
   logic                 neg_q,        neg_d;
   logic                 dz_q,         dz_d;
   logic [2*WIDTH-1:0]   acc_q,        acc_d;
   logic [CNT_W-1:0]     cnt_q,        cnt_d;
   logic [WIDTH-1:0]     res_lo_q,     res_lo_d;
   logic [WIDTH-1:0]     res_hi_q,     res_hi_d;
   logic                 div_zero_q,   div_zero_d;

   logic [2*WIDTH-1:0]   acc_step;
   logic [2*WIDTH-1:0]   acc_fix;
   logic [WIDTH-1:0]     a_mag;
   logic [WIDTH-1:0]     b_mag;
   logic                 is_smull;

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .op_is_div_i (op_q == MD_UDIV),
      .acc_i       (acc_q),
      .operand_i   (b_q),
      .acc_o       (acc_step)
   );

   // Magnitudes for SMULL. Negating the most-negative value in WIDTH bits
   // yields 2^(WIDTH-1), which is exactly its magnitude as an unsigned number.
   assign is_smull = (op_q == MD_SMULL);
   assign a_mag    = (is_smull && a_q[WIDTH-1]) ? -a_q : a_q;
   assign b_mag    = (is_smull && b_q[WIDTH-1]) ? -b_q : b_q;
   assign acc_fix  = neg_q ? -acc_q : acc_q;

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      a_d        = a_q;
      b_d        = b_q;
      neg_d      = neg_q;
      dz_d       = dz_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      res_lo_d   = res_lo_q;
      res_hi_d   = res_hi_q;
      div_zero_d = div_zero_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d    = md_op_e'(op);
               a_d     = a;
               b_d     = b;
               state_d = S_PREP;
            end
         end
         S_PREP: begin
            neg_d = is_smull && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
            dz_d  = 1'b0;
            cnt_d = CNT_W'(WIDTH - 1);
            if (op_q == MD_UDIV) begin
               if (b_q == '0) begin
                  // Zero divisor: preload the fixed result and skip RUN; FIX
                  // commits it, so done arrives two edges after start.
                  acc_d   = {a_q, {WIDTH{1'b1}}};
                  dz_d    = 1'b1;
                  state_d = S_FIX;
               end else begin
                  acc_d   = {{WIDTH{1'b0}}, a_q};
                  state_d = S_RUN;
               end
            end else begin
               // Multiplier sits in the low half and is consumed LSB first;
               // b_q now carries the multiplicand for the step unit.
               b_d     = a_mag;
               acc_d   = {{WIDTH{1'b0}}, b_mag};
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            acc_d = acc_step;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            res_lo_d   = acc_fix[WIDTH-1:0];
            res_hi_d   = (op_q == MD_MUL) ? '0 : acc_fix[2*WIDTH-1:WIDTH];
            div_zero_d = dz_q;
            state_d    = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // NOTE: sequential state is updated with non-blocking assignments so every
   // register samples its next value from the same pre-edge snapshot.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         op_q       <= MD_MUL;
         a_q        <= '0;
         b_q        <= '0;
         neg_q      <= 1'b0;
         dz_q       <= 1'b0;
         acc_q      <= '0;
         cnt_q      <= '0;
         res_lo_q   <= '0;
         res_hi_q   <= '0;
         div_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         a_q        <= a_d;
         b_q        <= b_d;
         neg_q      <= neg_d;
         dz_q       <= dz_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         res_lo_q   <= res_lo_d;
         res_hi_q   <= res_hi_d;
         div_zero_q <= div_zero_d;
      end
   end

   assign busy      = (state_q == S_PREP) || (state_q == S_RUN) || (state_q == S_FIX);
   assign done      = (state_q == S_DONE);
   assign result_lo = res_lo_q;
   assign result_hi = res_hi_q;
   assign div_zero  = div_zero_q;

endmodule
